// File: rtl/stage_scheduler.sv
// Cascade stage sequencer: per window, walks the stages, fetches weak
// counts and streams global feature addresses until a verdict arrives.
module stage_scheduler #(
  parameter  int STAGE_NUM     = 25,
  parameter  int MAX_WEAKCOUNT = 211,
  parameter  int W_FEAT_ADDR   = 12,
  localparam int W_ADDR_STAGE  = $clog2(STAGE_NUM),
  localparam int W_WEAKCOUNT   = $clog2(MAX_WEAKCOUNT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  output logic                    cnt_addr_valid,
  input  logic                    cnt_addr_ready,
  output logic [W_ADDR_STAGE-1:0] cnt_addr_data,
  input  logic                    cnt_valid,
  output logic                    cnt_ready,
  input  logic [W_WEAKCOUNT-1:0]  cnt_data,
  output logic                    feat_valid,
  input  logic                    feat_ready,
  output logic [W_FEAT_ADDR-1:0]  feat_addr,
  output logic                    feat_eot,
  input  logic                    result_valid,
  output logic                    result_ready,
  input  logic                    result,
  output logic                    flush,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic                    done_result,
  output logic [W_ADDR_STAGE:0]   done_stages,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_CNT,
    ISSUE,
    WAIT_RESULT,
    DONE
  } state_t;

  localparam logic [W_ADDR_STAGE-1:0] LAST_STAGE =
    W_ADDR_STAGE'(STAGE_NUM - 1);

  state_t                  state;
  logic [W_ADDR_STAGE-1:0] stage_idx;
  logic [W_FEAT_ADDR-1:0]  feat_base;
  logic [W_WEAKCOUNT-1:0]  weak_idx;
  logic [W_WEAKCOUNT-1:0]  count;
  logic                    feat_hs;
  logic                    result_hs;

  assign start_ready    = (state == IDLE);
  assign cnt_addr_valid = (state == FETCH);
  assign cnt_addr_data  = stage_idx;
  assign cnt_ready      = (state == WAIT_CNT);
  assign feat_valid     = (state == ISSUE);
  assign done_valid     = (state == DONE);
  assign busy           = (state != IDLE);
  assign result_ready   = (state != IDLE) && (state != DONE);

  assign feat_addr = feat_base + W_FEAT_ADDR'(weak_idx);
  assign feat_eot  = (state == ISSUE) &&
                     (weak_idx == count - W_WEAKCOUNT'(1));

  assign feat_hs   = feat_valid && feat_ready;
  assign result_hs = result_valid && result_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stage_idx   <= '0;
      feat_base   <= '0;
      weak_idx    <= '0;
      count       <= '0;
      done_stages <= '0;
      done_result <= 1'b0;
      flush       <= 1'b0;
    end else begin
      flush <= 1'b0;
      // A verdict wins over every other transition this cycle.
      if (result_hs) begin
        done_result <= result;
        flush       <= 1'b1;
        state       <= DONE;
        if (feat_hs && feat_eot)
          done_stages <= done_stages + (W_ADDR_STAGE+1)'(1);
      end else begin
        unique case (state)
          IDLE: begin
            if (start_valid) begin
              stage_idx   <= '0;
              feat_base   <= '0;
              weak_idx    <= '0;
              done_stages <= '0;
              state       <= FETCH;
            end
          end
          FETCH: begin
            if (cnt_addr_ready)
              state <= WAIT_CNT;
          end
          WAIT_CNT: begin
            if (cnt_valid) begin
              // Empty stages still emit one eot feature.
              count <= (cnt_data == '0) ? W_WEAKCOUNT'(1) : cnt_data;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            unique case (1'b1)
              !feat_ready: ;
              feat_ready && !feat_eot: begin
                weak_idx <= weak_idx + W_WEAKCOUNT'(1);
              end
              feat_ready && feat_eot: begin
                feat_base   <= feat_base + W_FEAT_ADDR'(count);
                weak_idx    <= '0;
                done_stages <= done_stages + (W_ADDR_STAGE+1)'(1);
                if (stage_idx == LAST_STAGE) begin
                  state <= WAIT_RESULT;
                end else begin
                  stage_idx <= stage_idx + W_ADDR_STAGE'(1);
                  state     <= FETCH;
                end
              end
              default: ;
            endcase
          end
          WAIT_RESULT: ;
          DONE: begin
            if (done_ready)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_scheduler.sv
// Scoreboard bench for stage_scheduler with a three-stage cascade
// and a single-cycle stage-count ROM model.
module tb_stage_scheduler;

  localparam int NS = 3;

  typedef struct packed {
    logic [11:0] addr;
    logic        eot;
  } feat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, start_ready;
  logic        cnt_addr_valid, cnt_addr_ready;
  logic [1:0]  cnt_addr_data;
  logic        cnt_valid, cnt_ready;
  logic [7:0]  cnt_data;
  logic        feat_valid, feat_ready;
  logic [11:0] feat_addr;
  logic        feat_eot;
  logic        result_valid, result_ready, result;
  logic        flush;
  logic        done_valid, done_ready, done_result;
  logic [2:0]  done_stages;
  logic        busy;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    cnts [NS];
  int    rom_addr = 0;
  feat_t sb [$];

  stage_scheduler #(.STAGE_NUM(NS)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .cnt_addr_valid(cnt_addr_valid), .cnt_addr_ready(cnt_addr_ready),
    .cnt_addr_data(cnt_addr_data),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_data(cnt_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_addr(feat_addr), .feat_eot(feat_eot),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .flush(flush),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_result(done_result), .done_stages(done_stages),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM answers in the cycle right after the address cycle
  always @(posedge clk) begin
    #1;
    if (cnt_addr_valid) rom_addr = int'(cnt_addr_data);
    cnt_valid = cnt_ready;
    cnt_data  = (cnt_ready && rom_addr < NS) ? 8'(cnts[rom_addr]) : 8'h00;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void push_exp();
    int    base = 0;
    int    c;
    feat_t e;
    for (int s = 0; s < NS; s++) begin
      c = (cnts[s] == 0) ? 1 : cnts[s];
      for (int i = 0; i < c; i++) begin
        e.addr = 12'(base + i);
        e.eot  = (i == c - 1);
        sb.push_back(e);
      end
      base += c;
    end
  endfunction

  task automatic start_window;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_valid = 0; cnt_addr_ready = 1; feat_ready = 0;
    result_valid = 0; result = 0; done_ready = 0;
    step(); step();
    checks++;
    if ({start_ready, busy, cnt_addr_valid, feat_valid} !== 4'b1000)
      $display("FAIL reset_ctl got %b exp 1000",
               {start_ready, busy, cnt_addr_valid, feat_valid});
    if ({start_ready, busy, cnt_addr_valid, feat_valid} !== 4'b1000)
      errors++;
    checks++;
    if ({flush, done_valid, done_result, result_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {flush, done_valid, done_result, result_ready});
    end
    checks++;
    if (feat_addr !== 12'h0 || done_stages !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs got %0h/%0d exp 0/0", feat_addr, done_stages);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_pass;
    int    n = 0;
    int    last_eot = -1;
    bit    prev_fv = 1'b1;
    feat_t e;
    cnts = '{2, 3, 1};
    sb.delete();
    push_exp();
    feat_ready = 1'b1;
    start_window();
    checks++;
    if (cnt_addr_valid !== 1'b1 || cnt_addr_data !== 2'd0) begin
      errors++;
      $display("FAIL fetch_t1 got %b/%0d exp 1/0", cnt_addr_valid, cnt_addr_data);
    end
    step();
    checks++;
    if (feat_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_feat got %b exp 0", feat_valid);
    end
    step();
    checks++;
    if (feat_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_feat_t3 got %b exp 1", feat_valid);
    end
    while (sb.size() > 0) begin
      if (n++ > 100) begin
        errors++;
        $display("FAIL full_timeout got %0d left exp 0", sb.size());
        break;
      end
      if (feat_valid && !prev_fv && last_eot >= 0) begin
        checks++;
        if (cyc - last_eot !== 3) begin
          errors++;
          $display("FAIL stage_bubble got %0d exp 3", cyc - last_eot);
        end
      end
      if (feat_valid) begin
        e = sb.pop_front();
        checks++;
        if (feat_addr !== e.addr || feat_eot !== e.eot) begin
          errors++;
          $display("FAIL full_feat got %0d/%b exp %0d/%b",
                   feat_addr, feat_eot, e.addr, e.eot);
        end
        if (feat_eot) last_eot = cyc;
      end
      prev_fv = feat_valid;
      step();
    end
    checks++;
    if (feat_valid !== 1'b0 || result_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_result got %b%b%b exp 011",
               feat_valid, result_ready, busy);
    end
    result_valid = 1'b1; result = 1'b1;
    step();
    result_valid = 1'b0;
    checks++;
    if ({flush, done_valid, done_result} !== 3'b111 || done_stages !== 3'd3) begin
      errors++;
      $display("FAIL full_done got %b%b%b/%0d exp 111/3",
               flush, done_valid, done_result, done_stages);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || done_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL full_idle got %b%b%b exp 000", busy, done_valid, flush);
    end
  endtask

  task automatic test_early_reject;
    int    n = 0;
    bit    hit = 1'b0;
    int    late = 0;
    feat_t e;
    cnts = '{2, 3, 1};
    sb.delete();
    push_exp();
    feat_ready = 1'b1;
    start_window();
    while (!hit) begin
      if (n++ > 100) begin
        errors++;
        $display("FAIL rej_timeout got %0d left exp addr 3", sb.size());
        break;
      end
      if (feat_valid) begin
        e = sb.pop_front();
        checks++;
        if (feat_addr !== e.addr || feat_eot !== e.eot) begin
          errors++;
          $display("FAIL rej_feat got %0d/%b exp %0d/%b",
                   feat_addr, feat_eot, e.addr, e.eot);
        end
        if (feat_addr == 12'd3) begin
          checks++;
          if (result_ready !== 1'b1) begin
            errors++;
            $display("FAIL rej_ready got %b exp 1", result_ready);
          end
          result_valid = 1'b1; result = 1'b0;
          hit = 1'b1;
        end
      end
      step();
    end
    result_valid = 1'b0;
    checks++;
    if ({flush, done_valid, done_result, feat_valid} !== 4'b1100 ||
        done_stages !== 3'd1) begin
      errors++;
      $display("FAIL rej_done got %b/%0d exp 1100/1",
               {flush, done_valid, done_result, feat_valid}, done_stages);
    end
    step();
    checks++;
    if (flush !== 1'b0 || done_valid !== 1'b1) begin
      errors++;
      $display("FAIL rej_pulse got %b%b exp 01", flush, done_valid);
    end
    for (int k = 0; k < 3; k++) begin
      if (feat_valid) late++;
      step();
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL rej_no_issue got %0d exp 0", late);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_backpressure;
    int          n = 0;
    bit          stalled = 1'b0;
    logic [11:0] p_addr = '0;
    logic        p_eot = 1'b0;
    bit          fin = 1'b0;
    feat_t       e;
    for (int s = 0; s < NS; s++) cnts[s] = $urandom_range(1, 4);
    sb.delete();
    push_exp();
    start_window();
    while (sb.size() > 0) begin
      if (n++ > 300) begin
        errors++;
        $display("FAIL bp_timeout got %0d left exp 0", sb.size());
        break;
      end
      feat_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        checks++;
        if (feat_valid !== 1'b1 || feat_addr !== p_addr || feat_eot !== p_eot) begin
          errors++;
          $display("FAIL bp_stable got %b/%0d/%b exp 1/%0d/%b",
                   feat_valid, feat_addr, feat_eot, p_addr, p_eot);
        end
      end
      if (feat_valid && feat_ready) begin
        e = sb.pop_front();
        checks++;
        if (feat_addr !== e.addr || feat_eot !== e.eot) begin
          errors++;
          $display("FAIL bp_feat got %0d/%b exp %0d/%b",
                   feat_addr, feat_eot, e.addr, e.eot);
        end
      end
      stalled = feat_valid && !feat_ready;
      p_addr = feat_addr;
      p_eot = feat_eot;
      step();
    end
    feat_ready = 1'b1;
    result_valid = 1'b1; result = 1'b1;
    step();
    result_valid = 1'b0;
    start_valid = 1'b1;
    n = 0;
    while (!fin) begin
      if (n++ > 50) begin
        errors++;
        $display("FAIL bp_done_timeout got busy %b exp 0", busy);
        break;
      end
      done_ready = 1'($urandom_range(0, 1));
      checks++;
      if ({done_valid, done_result, start_ready, feat_valid} !== 4'b1100 ||
          done_stages !== 3'(NS)) begin
        errors++;
        $display("FAIL bp_done got %b/%0d exp 1100/%0d",
                 {done_valid, done_result, start_ready, feat_valid},
                 done_stages, NS);
      end
      fin = done_ready;
      step();
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got %b%b exp 01", busy, start_ready);
    end
    step();
  endtask

  task automatic test_zero_count;
    int    n = 0;
    feat_t e;
    cnts = '{2, 0, 1};
    sb.delete();
    push_exp();
    feat_ready = 1'b1;
    start_window();
    while (sb.size() > 0) begin
      if (n++ > 100) begin
        errors++;
        $display("FAIL zero_timeout got %0d left exp 0", sb.size());
        break;
      end
      if (feat_valid) begin
        e = sb.pop_front();
        checks++;
        if (feat_addr !== e.addr || feat_eot !== e.eot) begin
          errors++;
          $display("FAIL zero_feat got %0d/%b exp %0d/%b",
                   feat_addr, feat_eot, e.addr, e.eot);
        end
      end
      step();
    end
    result_valid = 1'b1; result = 1'b1;
    step();
    result_valid = 1'b0;
    checks++;
    if (done_valid !== 1'b1 || done_stages !== 3'd3) begin
      errors++;
      $display("FAIL zero_done got %b/%0d exp 1/3", done_valid, done_stages);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int    n = 0;
    bit    hit = 1'b0;
    feat_t e;
    cnts = '{2, 3, 1};
    sb.delete();
    push_exp();
    feat_ready = 1'b1;
    start_window();
    while (!hit) begin
      if (n++ > 100) begin
        errors++;
        $display("FAIL rmid_timeout got %0d left exp stage 2", sb.size());
        break;
      end
      if (feat_valid && feat_addr == 12'd5) begin
        rst = 1'b1;
        hit = 1'b1;
      end else if (feat_valid) begin
        e = sb.pop_front();
        checks++;
        if (feat_addr !== e.addr) begin
          errors++;
          $display("FAIL rmid_feat got %0d exp %0d", feat_addr, e.addr);
        end
      end
      step();
    end
    rst = 1'b0;
    checks++;
    if ({start_ready, busy, feat_valid} !== 3'b100 || feat_addr !== 12'd0) begin
      errors++;
      $display("FAIL rmid_idle got %b/%0d exp 100/0",
               {start_ready, busy, feat_valid}, feat_addr);
    end
    start_window();
    checks++;
    if (cnt_addr_valid !== 1'b1 || cnt_addr_data !== 2'd0) begin
      errors++;
      $display("FAIL rmid_fetch got %b/%0d exp 1/0", cnt_addr_valid, cnt_addr_data);
    end
    step(); step();
    checks++;
    if (feat_valid !== 1'b1 || feat_addr !== 12'd0 || feat_eot !== 1'b0) begin
      errors++;
      $display("FAIL rmid_restart got %b/%0d/%b exp 1/0/0",
               feat_valid, feat_addr, feat_eot);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_result_idle;
    result_valid = 1'b1; result = 1'b1;
    checks++;
    if (result_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b exp 0", result_ready);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || done_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got %b%b%b exp 000", busy, done_valid, flush);
    end
    start_window();
    checks++;
    if (cnt_addr_valid !== 1'b1 || result_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_fetch got %b%b exp 11", cnt_addr_valid, result_ready);
    end
    step();
    result_valid = 1'b0;
    checks++;
    if ({flush, done_valid, done_result, cnt_ready} !== 4'b1110 ||
        done_stages !== 3'd0) begin
      errors++;
      $display("FAIL idle_done got %b/%0d exp 1110/0",
               {flush, done_valid, done_result, cnt_ready}, done_stages);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_back got %b exp 0", busy);
    end
  endtask

  initial begin
    cnts = '{1, 1, 1};
    test_reset();
    test_full_pass();
    test_early_reject();
    for (int r = 0; r < 4; r++) test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_result_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_scheduler.md
# stage_scheduler

Per-window sequencer for the cascade classifier's stage datapath. On a window start it walks the stages in order, fetches each stage's weak-classifier count from the stage-count ROM, and streams global feature addresses to the feature/leaf pipeline with an end-of-stage flag. It accepts the verdict produced by the stage accumulator, either an early reject or a final pass. On that verdict it aborts any further issue, flushes downstream, and reports one result per window.

## Interface
- STAGE_NUM, 25, number of cascade stages
- MAX_WEAKCOUNT, 211, maximum weak classifiers in one stage
- W_FEAT_ADDR, 12, global feature address width
- W_ADDR_STAGE (local), $clog2(STAGE_NUM), stage index width
- W_WEAKCOUNT (local), $clog2(MAX_WEAKCOUNT+1), weak count width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid / start_ready  in/out  1/1  begin new window
- cnt_addr_valid / cnt_addr_ready  out/in  1/1  stage-count ROM request
- cnt_addr_data  out  W_ADDR_STAGE  stage index
- cnt_valid / cnt_ready  in/out  1/1  stage-count ROM response
- cnt_data  in  W_WEAKCOUNT  weak count of requested stage
- feat_valid / feat_ready  out/in  1/1  feature issue handshake
- feat_addr  out  W_FEAT_ADDR  global feature index
- feat_eot  out  1  last feature of current stage (qualified by feat_valid)
- result_valid / result_ready  in/out  1/1  verdict from stage accumulator
- result  in  1  0 = reject, 1 = pass all stages
- flush  out  1  one-cycle pulse; downstream discards in-flight features
- done_valid / done_ready  out/in  1/1  window result handshake
- done_result  out  1  latched verdict
- done_stages  out  W_ADDR_STAGE+1  stages fully issued when verdict accepted
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, FETCH, WAIT_CNT, ISSUE, WAIT_RESULT, DONE.
- IDLE: start_ready=1. On start handshake, clear stage_idx, feat_base, weak_idx, and go to FETCH.
- FETCH: cnt_addr_valid=1, cnt_addr_data=stage_idx. On handshake go to WAIT_CNT.
- WAIT_CNT: cnt_ready=1. On cnt_valid, latch count and go to ISSUE. A count of 0 is clamped to 1, so every stage emits exactly one eot.
- ISSUE: feat_valid=1, feat_addr=feat_base+weak_idx (mod 2^W_FEAT_ADDR), feat_eot=(weak_idx==count-1).
  - On each handshake, weak_idx++.
  - On the eot handshake: feat_base+=count, weak_idx=0, done_stages++.
  - After eot: if stage_idx==STAGE_NUM-1 go to WAIT_RESULT; otherwise stage_idx++ and go to FETCH.
- result_ready=1 in FETCH, WAIT_CNT, ISSUE and WAIT_RESULT; 0 in IDLE and DONE.
- On result handshake: latch done_result=result, pulse flush for one cycle, go to DONE. Result acceptance has priority over every other transition in that cycle.
- If a feat handshake coincides with result acceptance, the feature counts as transferred (done_stages updates if it was eot), and flush covers it.
- DONE: done_valid=1, outputs stable until done_ready, then go to IDLE.
- Reset: from any state, go to IDLE and zero all counters. Reset values: all valid/ready outputs 0 except start_ready=1, flush=0, done_result=0, done_stages=0, busy=0, feat_addr=0.

## Timing
- No combinational paths from input to output except ready/valid decode from state; all outputs are state- or register-driven.
- Start accepted at cycle T: cnt_addr_valid at T+1.
- ROM answers one cycle after address: first feat_valid at T+3.
- Stage-to-stage bubble: eot handshake at cycle E gives FETCH at E+1; with single-cycle ROM, next feat_valid at E+3.
- Back-to-back features within a stage: one per cycle while feat_ready=1.
- flush asserted exactly in the cycle after result acceptance; done_valid in the same cycle.
- start_valid held during DONE is not accepted until the cycle after the done handshake.

## Test plan
- STAGE_NUM=3, counts {2,3,1}, feat_ready=1, result=1 after last eot -> feat_addr 0,1,2,3,4,5; eot on addr 1,4,5; done_result=1, done_stages=3.
- Same counts, result=0 asserted while issuing addr 3 -> result accepted that cycle, flush one pulse, no feat_valid afterwards, done_result=0, done_stages=1.
- Random feat_ready and done_ready backpressure -> no feature dropped or duplicated, feat_addr/feat_eot stable while stalled, done outputs stable until handshake.
- cnt_data=0 for stage 1 -> a single feature with eot issued for stage 1, feat_base advances by 1.
- rst asserted mid-ISSUE at stage 2 -> next cycle IDLE, start_ready=1, busy=0; a new start reissues from feat_addr 0 via stage 0.
- result_valid while IDLE -> result_ready=0 and no state change; after start, the pending result is accepted in FETCH and done follows.
